goomba_sprite_renderer: RTL
===========================

// Module: goomba_sprite_renderer
// PURPOSE
//  Upstream driver of the goomba sprite ROMs (walk_1, walk_2, squished; 20x22 px, 9-bit address, 12-bit colour).
//  Per requested pixel (DrawX,DrawY) it hit-tests the goomba bounding box and forms the ROM address, mirrored by facing.
//  It selects the ROM frame from an animation/life FSM, then registers the returned colour with a chroma-key flag.
//  Its output feeds the colour mapper's layer priority mux.
// PARAMETERS
//  SPRITE_W       20      sprite width, px
//  SPRITE_H       22      sprite height, px
//  ANIM_FRAMES    8       frame_ticks per walk_1/walk_2 toggle
//  SQUISH_FRAMES  30      frame_ticks the squished frame is shown before DEAD
//  KEY_COLOR      12'h808 transparent chroma key
// PORTS
//  Clk           in   1   system clock, all logic on rising edge
//  Reset_n       in   1   synchronous, active-low reset
//  frame_tick    in   1   one-cycle pulse per video frame (vsync rise)
//  spawn         in   1   pulse: (re)start goomba in WALK
//  stomp         in   1   pulse: Mario landed on goomba
//  goomba_x      in   10  left edge, screen px (0..639)
//  goomba_y      in   10  top edge, screen px (0..479)
//  goomba_dir    in   1   0 = facing left (native), 1 = facing right (mirror)
//  pix_req       in   1   DrawX/DrawY valid this cycle
//  DrawX         in   10  current pixel column
//  DrawY         in   10  current pixel row
//  read_address  out  9   ROM address, row*SPRITE_W + col
//  frame_sel     out  2   0 walk_1, 1 walk_2, 2 squished (drives ROM mux)
//  rom_color     in   12  muxed ROM output, combinational from read_address/frame_sel
//  pixel_valid   out  1   pixel_color/pixel_opaque valid
//  pixel_color   out  12  sprite colour
//  pixel_opaque  out  1   1 = inside box AND colour != KEY_COLOR
//  goomba_state  out  2   IDLE/WALK/SQUISH/DEAD, for game logic
// BEHAVIOUR
//  Reset: read_address=0, frame_sel=0, pixel_valid=0, pixel_color=0, pixel_opaque=0, state=IDLE, counters=0.
//  FSM (advances on clock; counters advance on frame_tick only):
//   IDLE  -spawn-> WALK;  DEAD -spawn-> WALK;  WALK -stomp-> SQUISH
//   SQUISH: count frame_ticks; on SQUISH_FRAMES-th tick -> DEAD.  stomp ignored outside WALK.
//   spawn in any state -> WALK, anim counter=0, frame=walk_1; spawn wins over simultaneous stomp.
//   stomp + frame_tick same cycle: stomp taken, squish counter starts at 0 (that tick not counted).
//  Animation: in WALK, anim counter counts frame_ticks 0..ANIM_FRAMES-1; wrap toggles walk_1<->walk_2.
//  frame_sel: WALK -> current walk frame; SQUISH -> 2; IDLE/DEAD -> 0 (output suppressed anyway).
//  Pipeline, latency 2:
//   S1 (cycle N): dx=DrawX-goomba_x, dy=DrawY-goomba_y in 11-bit; hit = DrawX>=goomba_x &&
//     DrawX<goomba_x+SPRITE_W && DrawY>=goomba_y && DrawY<goomba_y+SPRITE_H (11-bit sums, no wrap at screen edge).
//     col = dir ? SPRITE_W-1-dx : dx;  addr = dy*SPRITE_W + col (max 439, fits 9 bits).
//     Registered: read_address (held if no hit), frame_sel, hit_q = pix_req&&hit&&state in {WALK,SQUISH}, req_q=pix_req.
//   S2 (cycle N+1): rom_color sampled; pixel_color<=rom_color; pixel_opaque<=hit_q && rom_color!=KEY_COLOR;
//     pixel_valid<=req_q.  Result visible at N+2.
//  No pix_req: pipeline still shifts, pixel_valid=0 at N+2. Back-to-back requests every cycle supported.
//  Position/dir/state change mid-frame takes effect on next S1 sample; no tearing protection.
//  Reset mid-operation: in-flight pixels dropped (pixel_valid=0 the cycle after reset asserted).
// STRUCTURE
//  goomba_pkg: state enum {IDLE,WALK,SQUISH,DEAD}, frame_sel encodings, SPRITE_W/H, KEY_COLOR defaults.
//  Sub-module goomba_anim_fsm: state, anim and squish counters, frame_sel; top holds hit-test and 2-stage pipe.
//  Address multiply as shift-add (dy<<4 + dy<<2) for SPRITE_W=20; generic * elsewhere.
// TESTING
//  1 Reset, spawn, goomba_x=100,y=200,dir=0, req (100,200) -> read_address=0 at N+1, pixel_valid=1 at N+2.
//  2 req (119,221) dir=0 -> addr 439; dir=1 -> addr 420; req (120,200) -> pixel_opaque=0.
//  3 rom_color=12'h808 inside box -> pixel_opaque=0; 12'hE51 -> pixel_opaque=1, pixel_color=E51.
//  4 WALK, 8 frame_ticks -> frame_sel 0->1; 16 ticks -> back to 0.
//  5 stomp -> SQUISH, frame_sel=2; 30 ticks -> DEAD, opaque=0 everywhere; spawn -> WALK, frame_sel=0.
//  6 spawn+stomp same cycle in WALK -> stays WALK, anim counter cleared; Reset_n low mid-stream -> pixel_valid=0.

Source files
------------

// File: rtl/goomba_pkg.sv
// Shared types and defaults for the goomba sprite renderer: life states,
// ROM frame encodings and sprite geometry.
package goomba_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_SQUISH = 2'd2,
    ST_DEAD   = 2'd3
  } goomba_state_e;

  localparam logic [1:0] FRM_WALK1  = 2'd0;
  localparam logic [1:0] FRM_WALK2  = 2'd1;
  localparam logic [1:0] FRM_SQUISH = 2'd2;

  localparam int          SPRITE_W_DEF      = 20;
  localparam int          SPRITE_H_DEF      = 22;
  localparam int          ANIM_FRAMES_DEF   = 8;
  localparam int          SQUISH_FRAMES_DEF = 30;
  localparam logic [11:0] KEY_COLOR_DEF     = 12'h808;

  // Only a live goomba (walking or being squished) puts pixels on screen.
  function automatic logic is_visible(input logic [1:0] st);
    return (st == ST_WALK) || (st == ST_SQUISH);
  endfunction

endpackage

// File: rtl/goomba_anim_fsm.sv
// Goomba life/animation FSM: tracks IDLE/WALK/SQUISH/DEAD, the walk-cycle
// frame and the squish hold time, and registers the ROM frame select.
module goomba_anim_fsm
  import goomba_pkg::*;
#(
  parameter int ANIM_FRAMES   = ANIM_FRAMES_DEF,
  parameter int SQUISH_FRAMES = SQUISH_FRAMES_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic       stomp,
  output logic [1:0] state,
  output logic [1:0] frame_sel
);

  localparam int AW = $clog2(ANIM_FRAMES + 1);
  localparam int SW = $clog2(SQUISH_FRAMES + 1);
  localparam logic [AW-1:0] ANIM_LAST   = AW'(ANIM_FRAMES - 1);
  localparam logic [SW-1:0] SQUISH_LAST = SW'(SQUISH_FRAMES - 1);

  goomba_state_e st;
  logic [AW-1:0] anim_cnt;
  logic [SW-1:0] squish_cnt;
  logic          walk_frame;

  assign state = st;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      st         <= ST_IDLE;
      anim_cnt   <= '0;
      squish_cnt <= '0;
      walk_frame <= 1'b0;
      frame_sel  <= FRM_WALK1;
    end else if (spawn) begin
      // spawn restarts from any state and beats a simultaneous stomp
      st         <= ST_WALK;
      anim_cnt   <= '0;
      squish_cnt <= '0;
      walk_frame <= 1'b0;
      frame_sel  <= FRM_WALK1;
    end else begin
      unique case (st)
        ST_WALK: begin
          if (stomp) begin
            // a frame_tick in the same cycle is not counted toward the squish
            st         <= ST_SQUISH;
            squish_cnt <= '0;
            frame_sel  <= FRM_SQUISH;
          end else if (frame_tick) begin
            if (anim_cnt == ANIM_LAST) begin
              anim_cnt   <= '0;
              walk_frame <= ~walk_frame;
              frame_sel  <= walk_frame ? FRM_WALK1 : FRM_WALK2;
            end else begin
              anim_cnt <= anim_cnt + AW'(1);
            end
          end
        end
        ST_SQUISH: begin
          if (frame_tick) begin
            if (squish_cnt == SQUISH_LAST) begin
              st         <= ST_DEAD;
              squish_cnt <= '0;
              frame_sel  <= FRM_WALK1;
            end else begin
              squish_cnt <= squish_cnt + SW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/goomba_sprite_renderer.sv
// Goomba sprite front end: hit-tests each requested pixel against the sprite
// box, addresses the frame ROM (mirrored by facing) and keys out the chroma colour.
module goomba_sprite_renderer
  import goomba_pkg::*;
#(
  parameter int          SPRITE_W      = SPRITE_W_DEF,
  parameter int          SPRITE_H      = SPRITE_H_DEF,
  parameter int          ANIM_FRAMES   = ANIM_FRAMES_DEF,
  parameter int          SQUISH_FRAMES = SQUISH_FRAMES_DEF,
  parameter logic [11:0] KEY_COLOR     = KEY_COLOR_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        spawn,
  input  logic        stomp,
  input  logic [9:0]  goomba_x,
  input  logic [9:0]  goomba_y,
  input  logic        goomba_dir,
  input  logic        pix_req,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [8:0]  read_address,
  output logic [1:0]  frame_sel,
  input  logic [11:0] rom_color,
  output logic        pixel_valid,
  output logic [11:0] pixel_color,
  output logic        pixel_opaque,
  output logic [1:0]  goomba_state
);

  logic [1:0] fsm_state;
  logic [1:0] fsm_frame;

  goomba_anim_fsm #(
    .ANIM_FRAMES   (ANIM_FRAMES),
    .SQUISH_FRAMES (SQUISH_FRAMES)
  ) u_anim_fsm (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .spawn      (spawn),
    .stomp      (stomp),
    .state      (fsm_state),
    .frame_sel  (fsm_frame)
  );

  assign goomba_state = fsm_state;

  // S1: 11-bit geometry so a sprite near the right/bottom edge never wraps.
  logic [10:0] draw_x, draw_y, org_x, org_y;
  logic [10:0] dx, dy, col;
  logic        hit;

  assign draw_x = {1'b0, DrawX};
  assign draw_y = {1'b0, DrawY};
  assign org_x  = {1'b0, goomba_x};
  assign org_y  = {1'b0, goomba_y};
  assign dx     = draw_x - org_x;
  assign dy     = draw_y - org_y;
  assign hit    = (draw_x >= org_x) && (draw_x < org_x + 11'(SPRITE_W)) &&
                  (draw_y >= org_y) && (draw_y < org_y + 11'(SPRITE_H));
  assign col    = goomba_dir ? (11'(SPRITE_W - 1) - dx) : dx;

  logic [15:0] row_base, addr_full;

  generate
    if (SPRITE_W == 20) begin : g_shift_add
      assign row_base = ({5'b0, dy} << 4) + ({5'b0, dy} << 2);
    end else begin : g_mul
      assign row_base = {5'b0, dy} * 16'(SPRITE_W);
    end
  endgenerate

  assign addr_full = row_base + {5'b0, col};

  // Upper address bits only matter for off-sprite pixels, whose address is discarded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_full[15:9];

  logic       hit_q;
  logic [1:0] vld_pipe;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      read_address <= '0;
      frame_sel    <= FRM_WALK1;
      hit_q        <= 1'b0;
      vld_pipe     <= '0;
      pixel_color  <= '0;
      pixel_opaque <= 1'b0;
    end else begin
      if (hit) read_address <= addr_full[8:0];
      frame_sel    <= fsm_frame;
      hit_q        <= pix_req && hit && is_visible(fsm_state);
      vld_pipe     <= {vld_pipe[0], pix_req};
      pixel_color  <= rom_color;
      pixel_opaque <= hit_q && (rom_color != KEY_COLOR);
    end
  end

  assign pixel_valid = vld_pipe[1];

endmodule
